imm_extend_stage: RTL



---
 rtl/imm_extend_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/imm_extend_stage.sv
// Pipelined immediate extender: widens an IN_W-bit immediate to OUT_W bits (zero/sign/upper/branch)
// behind a registered output stage with a 2-entry skid buffer and valid/ready handshakes.
module imm_extend_stage #(
    parameter int IN_W     = 6,
    parameter int OUT_W    = 32,
    parameter int TAG_W    = 4,
    parameter int BR_SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PAD_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_ZERO   = 2'b00;
    localparam logic [1:0] MODE_SIGN   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    function automatic logic [OUT_W-1:0] extend_imm(
        input logic [IN_W-1:0] imm,
        input logic [1:0]      mode
    );
        logic [OUT_W-1:0] sext;
        sext = {{PAD_W{imm[IN_W-1]}}, imm};
        case (mode)
            MODE_ZERO:   extend_imm = {{PAD_W{1'b0}}, imm};
            MODE_SIGN:   extend_imm = sext;
            MODE_UPPER:  extend_imm = {imm, {PAD_W{1'b0}}};
            MODE_BRANCH: extend_imm = sext << BR_SHIFT;
            default:     extend_imm = {OUT_W{1'b0}};
        endcase
    endfunction

    logic             o_valid_r;
    logic             s_valid_r;
    logic [OUT_W-1:0] o_data_r;
    logic [OUT_W-1:0] s_data_r;
    logic [TAG_W-1:0] o_tag_r;
    logic [TAG_W-1:0] s_tag_r;
    logic [OUT_W-1:0] ext_data_s;
    logic             accept_s;
    logic             deliver_s;

    // Extension happens once on the input side; stored results are never recomputed.
    always_comb begin
        ext_data_s = extend_imm(in_imm, in_mode);
    end

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
    assign in_ready  = ~s_valid_r;
    assign accept_s  = in_valid & ~s_valid_r;
    assign deliver_s = o_valid_r & out_ready;

    assign out_valid = o_valid_r;
    assign out_data  = o_data_r;
    assign out_tag   = o_tag_r;

    // Output/skid register pair: EMPTY -> ONE -> FULL occupancy with strict FIFO order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_r <= 1'b0;
            s_valid_r <= 1'b0;
            o_data_r  <= {OUT_W{1'b0}};
            s_data_r  <= {OUT_W{1'b0}};
            o_tag_r   <= {TAG_W{1'b0}};
            s_tag_r   <= {TAG_W{1'b0}};
        end else begin
            if (s_valid_r) begin
                // FULL: nothing is accepted; a delivery promotes the skid entry.
                if (deliver_s) begin
                    o_data_r  <= s_data_r;
                    o_tag_r   <= s_tag_r;
                    s_valid_r <= 1'b0;
                end
            end else if (accept_s) begin
                if (!o_valid_r || deliver_s) begin
                    o_data_r  <= ext_data_s;
                    o_tag_r   <= in_tag;
                    o_valid_r <= 1'b1;
                end else begin
                    s_data_r  <= ext_data_s;
                    s_tag_r   <= in_tag;
                    s_valid_r <= 1'b1;
                end
            end else if (deliver_s) begin
                o_valid_r <= 1'b0;
            end
        end
    end

endmodule
